ray_sampler: RTL and testbench
==============================

Name: ray_sampler

Overview:
- Consumes one ray (rays_o, rays_d, from the ray-generation stage) per valid/ready transaction.
- Emits N_SAMPLES 3-D sample points p_k = o + t_k*d, with t_k = near + k*delta, one point per output handshake, toward the positional encoder / MLP front end.
- All arithmetic is signed fixed point, Q12.4 (16 bits, 4 fraction bits), consistent with the ray-generation stage.

Parameters:
- NTOTAL_BITS, 16, total bits of every fixed-point word.
- NFRAC_BITS, 4, fraction bits.
- N_SAMPLES, 8, samples per ray (≥2).
- IDX_W, 3, width of sample index; must equal clog2(N_SAMPLES).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  ray input valid.
- in_ready  out  1  ray input ready.
- ray_o_x / ray_o_y / ray_o_z  in  NTOTAL_BITS each  ray origin, signed Q12.4.
- ray_d_x / ray_d_y / ray_d_z  in  NTOTAL_BITS each  ray direction, signed Q12.4.
- t_near  in  NTOTAL_BITS  first sample depth, signed Q12.4.
- t_delta  in  NTOTAL_BITS  depth step, signed Q12.4.
- out_valid  out  1  sample valid.
- out_ready  in  1  downstream ready.
- pt_x / pt_y / pt_z  out  NTOTAL_BITS each  sample point, signed Q12.4.
- pt_t  out  NTOTAL_BITS  depth t_k of this sample.
- pt_idx  out  IDX_W  sample index k.
- pt_last  out  1  high when k == N_SAMPLES-1.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; out_valid=0; in_ready=1; pt_x/y/z, pt_t, pt_idx=0; pt_last=0. Reset overrides everything, including mid-ray: the remaining samples are dropped and the ray is not resumed.
- Multiply rule mul(a,b): full signed 32-bit product, result = product[19:4]. Truncation is floor (arithmetic shift), no rounding, no saturation.
- Add rule: 16-bit two's-complement, wraps silently.
- Formulas:
  - t_k = t_near + k*t_delta, formed incrementally: t_{k+1} = t_k + t_delta, wrapping.
  - pt_c = o_c + mul(t_k, d_c) for each component c.
- States: IDLE, EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: register o, d, t_delta; load pt_* for k=0 (t=t_near); pt_idx=0; pt_last=0; go EMIT.
  - Latency: first sample is valid the cycle after the input handshake.
- EMIT:
  - in_ready=0, out_valid=1.
  - pt_* are registers and hold stable while out_ready=0.
  - On out_ready with k<N_SAMPLES-1: load sample k+1 next cycle. Back-to-back samples: 1 per cycle when out_ready stays high.
  - pt_last=1 exactly for k=N_SAMPLES-1.
  - On out_ready with pt_last=1: go IDLE. out_valid=0 and in_ready=1 in the next cycle.
- No overlap between rays: a ray takes ≥N_SAMPLES+1 cycles (one IDLE accept cycle, then N_SAMPLES emit cycles).
- Input port values are sampled only at the input handshake; later changes on those ports have no effect on the current ray.
- out_valid never drops without a handshake, except on reset.
- Implementation may use one multiplier per component, computing from the registered t and d.

Test Plan:
1. Nominal ray:
   - Stimulus: o=(0x0010,0x0020,0x0030), d=(0x0010,0x0000,0xFFF0), t_near=0x0020, t_delta=0x0008, out_ready=1.
   - Required: k=0 gives pt=(0x0030,0x0020,0x0010), t=0x0020. k=7 gives pt=(0x0068,0x0020,0xFFD8), t=0x0058, pt_last=1.
   - Required: exactly 8 samples on consecutive cycles; in_ready=1 on the cycle after the last sample.
2. Truncation:
   - Stimulus: d_x=0x0001, t_near=0x0018, o=0 → required pt_x=0x0001.
   - Stimulus: d_x=0xFFFF → required pt_x=0xFFFE (floor, not round).
3. Wrap:
   - Stimulus: o_x=0x7FF0, d_x=0x0010, t_near=0x0020.
   - Required: pt_x=0x8010 (wraps), no saturation.
4. Backpressure:
   - Stimulus: out_ready low for 3 cycles at k=3.
   - Required: pt_* and pt_idx=3 held stable with out_valid=1; the sequence resumes at k=4 with no skip or duplicate.
   - Stimulus: in_valid held high throughout → required: no second ray accepted until after the last sample.
5. Reset mid-ray:
   - Stimulus: rst_n=0 for one cycle at k=5.
   - Required: next cycle out_valid=0, in_ready=1, all outputs 0. A new ray then starts at pt_idx=0.
6. Input sampling:
   - Stimulus: change ray_o/ray_d/t_delta during EMIT.
   - Required: emitted samples are unchanged and still use the values captured at the handshake.

Source files
------------

// File: rtl/ray_sampler.sv
// Ray sampler: accepts one ray and emits N_SAMPLES points p_k = o + t_k*d in
// signed fixed point, one point per output handshake.
module ray_sampler #(
  parameter int NTOTAL_BITS = 16,
  parameter int NFRAC_BITS  = 4,
  parameter int N_SAMPLES   = 8,
  parameter int IDX_W       = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NTOTAL_BITS-1:0] ray_o_x,
  input  logic [NTOTAL_BITS-1:0] ray_o_y,
  input  logic [NTOTAL_BITS-1:0] ray_o_z,
  input  logic [NTOTAL_BITS-1:0] ray_d_x,
  input  logic [NTOTAL_BITS-1:0] ray_d_y,
  input  logic [NTOTAL_BITS-1:0] ray_d_z,
  input  logic [NTOTAL_BITS-1:0] t_near,
  input  logic [NTOTAL_BITS-1:0] t_delta,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NTOTAL_BITS-1:0] pt_x,
  output logic [NTOTAL_BITS-1:0] pt_y,
  output logic [NTOTAL_BITS-1:0] pt_z,
  output logic [NTOTAL_BITS-1:0] pt_t,
  output logic [IDX_W-1:0]       pt_idx,
  output logic                   pt_last
);

  localparam int W  = NTOTAL_BITS;
  localparam int PW = 2 * NTOTAL_BITS;
  localparam logic [IDX_W-1:0] PEN_IDX = IDX_W'(N_SAMPLES - 2);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t state_q, state_d;

  logic [W-1:0]     ox_q, oy_q, oz_q;
  logic [W-1:0]     dx_q, dy_q, dz_q;
  logic [W-1:0]     delta_q, t_q;
  logic [W-1:0]     px_q, py_q, pz_q;
  logic [IDX_W-1:0] idx_q;
  logic             last_q;

  logic             accept, advance;
  logic [W-1:0]     t_op, ox_op, oy_op, oz_op, dx_op, dy_op, dz_op;
  logic [W-1:0]     px_d, py_d, pz_d;

  // Full signed product, floor-truncated back to the working format.
  function automatic logic [W-1:0] mul(input logic signed [W-1:0] a,
                                       input logic signed [W-1:0] b);
    logic signed [PW-1:0] p;
    p = PW'(a) * PW'(b);
    return p[NFRAC_BITS +: W];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_q) state_d = IDLE;
          else        advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One multiplier per axis: operands come straight from the ports while idle
  // (sample 0) and from the captured ray with the next depth while emitting.
  always_comb begin
    if (state_q == IDLE) begin
      t_op  = t_near;
      ox_op = ray_o_x;
      oy_op = ray_o_y;
      oz_op = ray_o_z;
      dx_op = ray_d_x;
      dy_op = ray_d_y;
      dz_op = ray_d_z;
    end else begin
      t_op  = t_q + delta_q;
      ox_op = ox_q;
      oy_op = oy_q;
      oz_op = oz_q;
      dx_op = dx_q;
      dy_op = dy_q;
      dz_op = dz_q;
    end
    px_d = ox_op + mul(t_op, dx_op);
    py_d = oy_op + mul(t_op, dy_op);
    pz_d = oz_op + mul(t_op, dz_op);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ox_q    <= '0;
      oy_q    <= '0;
      oz_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      dz_q    <= '0;
      delta_q <= '0;
      t_q     <= '0;
      px_q    <= '0;
      py_q    <= '0;
      pz_q    <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else if (accept) begin
      ox_q    <= ray_o_x;
      oy_q    <= ray_o_y;
      oz_q    <= ray_o_z;
      dx_q    <= ray_d_x;
      dy_q    <= ray_d_y;
      dz_q    <= ray_d_z;
      delta_q <= t_delta;
      t_q     <= t_op;
      px_q    <= px_d;
      py_q    <= py_d;
      pz_q    <= pz_d;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else if (advance) begin
      t_q     <= t_op;
      px_q    <= px_d;
      py_q    <= py_d;
      pz_q    <= pz_d;
      idx_q   <= idx_q + 1'b1;
      last_q  <= (idx_q == PEN_IDX);
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign pt_x      = px_q;
  assign pt_y      = py_q;
  assign pt_z      = pz_q;
  assign pt_t      = t_q;
  assign pt_idx    = idx_q;
  assign pt_last   = last_q;

endmodule

// File: tb/tb_ray_sampler.sv
// Self-checking bench for ray_sampler: table-driven rays plus a scoreboard
// filled at each input handshake and drained at each output handshake.
module tb_ray_sampler;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] ray_o_x = '0, ray_o_y = '0, ray_o_z = '0;
  logic [15:0] ray_d_x = '0, ray_d_y = '0, ray_d_z = '0;
  logic [15:0] t_near = '0, t_delta = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] pt_x, pt_y, pt_z, pt_t;
  logic [2:0]  pt_idx;
  logic        pt_last;

  ray_sampler #(.NTOTAL_BITS(16), .NFRAC_BITS(4), .N_SAMPLES(N), .IDX_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ray_o_x(ray_o_x), .ray_o_y(ray_o_y), .ray_o_z(ray_o_z),
    .ray_d_x(ray_d_x), .ray_d_y(ray_d_y), .ray_d_z(ray_d_z),
    .t_near(t_near), .t_delta(t_delta),
    .out_valid(out_valid), .out_ready(out_ready),
    .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z), .pt_t(pt_t),
    .pt_idx(pt_idx), .pt_last(pt_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ox, oy, oz, dx, dy, dz, near, delta;
    logic [15:0] e0x, e0y, e0z, e0t;
    logic [15:0] elx, ely, elz, elt;
  } row_t;

  typedef struct {
    logic [15:0] x, y, z, t;
    logic [2:0]  idx;
    logic        last;
  } samp_t;

  int    checks = 0;
  int    failures = 0;
  samp_t sbq[$];
  samp_t last_seen;
  int    nsamp = 0;
  row_t  rows[6];

  function automatic logic [15:0] mpt(input logic [15:0] o, input logic [15:0] t,
                                      input logic [15:0] d);
    int p;
    p = int'($signed(t)) * int'($signed(d));
    p = p >>> 4;
    return o + p[15:0];
  endfunction

  // Monitor / scoreboard
  logic        hold_v = 1'b0;
  logic [15:0] h_x, h_y, h_z, h_t;
  logic [2:0]  h_idx;
  always @(negedge clk) begin
    samp_t s, e;
    logic [15:0] tk;
    if (!rst_n) begin
      sbq.delete();
      hold_v = 1'b0;
    end else begin
      checks++;
      if (out_valid && in_ready) begin
        failures++;
        $display("FAIL busy_excl: out_valid=%0b in_ready=%0b, want not both 1", out_valid, in_ready);
      end
      if (hold_v) begin
        checks++;
        if (!out_valid || pt_x != h_x || pt_y != h_y || pt_z != h_z || pt_t != h_t || pt_idx != h_idx) begin
          failures++;
          $display("FAIL hold: got v=%0b (%h,%h,%h) t=%h idx=%0d want v=1 (%h,%h,%h) t=%h idx=%0d",
                   out_valid, pt_x, pt_y, pt_z, pt_t, pt_idx, h_x, h_y, h_z, h_t, h_idx);
        end
      end
      if (in_valid && in_ready) begin
        for (int k = 0; k < N; k++) begin
          tk = t_near + 16'(k) * t_delta;
          e.t = tk;
          e.x = mpt(ray_o_x, tk, ray_d_x);
          e.y = mpt(ray_o_y, tk, ray_d_y);
          e.z = mpt(ray_o_z, tk, ray_d_z);
          e.idx = 3'(k);
          e.last = (k == N - 1);
          sbq.push_back(e);
        end
      end
      if (out_valid && out_ready) begin
        s.x = pt_x; s.y = pt_y; s.z = pt_z; s.t = pt_t; s.idx = pt_idx; s.last = pt_last;
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL sb_extra: got unexpected sample idx=%0d, want none", pt_idx);
        end else begin
          e = sbq.pop_front();
          if (s != e) begin
            failures++;
            $display("FAIL sb_sample: got (%h,%h,%h) t=%h idx=%0d last=%0b want (%h,%h,%h) t=%h idx=%0d last=%0b",
                     s.x, s.y, s.z, s.t, s.idx, s.last, e.x, e.y, e.z, e.t, e.idx, e.last);
          end
        end
        last_seen = s;
        nsamp++;
      end
      hold_v = out_valid && !out_ready;
      h_x = pt_x; h_y = pt_y; h_z = pt_z; h_t = pt_t; h_idx = pt_idx;
    end
  end

  task automatic scramble();
    ray_o_x = 16'($urandom); ray_o_y = 16'($urandom); ray_o_z = 16'($urandom);
    ray_d_x = 16'($urandom); ray_d_y = 16'($urandom); ray_d_z = 16'($urandom);
    t_near  = 16'($urandom); t_delta = 16'($urandom);
  endtask

  task automatic drive(input row_t r);
    ray_o_x = r.ox; ray_o_y = r.oy; ray_o_z = r.oz;
    ray_d_x = r.dx; ray_d_y = r.dy; ray_d_z = r.dz;
    t_near = r.near; t_delta = r.delta;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got in_ready=0, want 1 within 100 cycles", name);
    end
  endtask

  task automatic send_row(input row_t r);
    int cyc;
    int n0;
    @(posedge clk); #1;
    drive(r);
    in_valid = 1'b1;
    wait_ready("accept");
    n0 = nsamp;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    @(negedge clk);
    checks++;
    if (!out_valid || pt_x != r.e0x || pt_y != r.e0y || pt_z != r.e0z || pt_t != r.e0t || pt_idx != 3'd0) begin
      failures++;
      $display("FAIL first: got v=%0b (%h,%h,%h) t=%h idx=%0d want v=1 (%h,%h,%h) t=%h idx=0",
               out_valid, pt_x, pt_y, pt_z, pt_t, pt_idx, r.e0x, r.e0y, r.e0z, r.e0t);
    end
    cyc = 0;
    while (out_valid && cyc < 64) begin
      cyc++;
      @(posedge clk); #1;
      scramble();
      @(negedge clk);
    end
    checks++;
    if (cyc != N || !in_ready || nsamp - n0 != N) begin
      failures++;
      $display("FAIL burst: got cycles=%0d samples=%0d in_ready=%0b want cycles=%0d samples=%0d in_ready=1",
               cyc, nsamp - n0, in_ready, N, N);
    end
    checks++;
    if (last_seen.x != r.elx || last_seen.y != r.ely || last_seen.z != r.elz ||
        last_seen.t != r.elt || last_seen.idx != 3'(N - 1) || !last_seen.last) begin
      failures++;
      $display("FAIL last: got (%h,%h,%h) t=%h idx=%0d last=%0b want (%h,%h,%h) t=%h idx=7 last=1",
               last_seen.x, last_seen.y, last_seen.z, last_seen.t, last_seen.idx, last_seen.last,
               r.elx, r.ely, r.elz, r.elt);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    //        ox       oy       oz       dx       dy       dz       near     delta
    //        e0x      e0y      e0z      e0t      elx      ely      elz      elt
    rows[0] = '{16'h0010, 16'h0020, 16'h0030, 16'h0010, 16'h0000, 16'hFFF0, 16'h0020, 16'h0008,
                16'h0030, 16'h0020, 16'h0010, 16'h0020, 16'h0068, 16'h0020, 16'hFFD8, 16'h0058};
    rows[1] = '{16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0018, 16'h0000,
                16'h0001, 16'h0000, 16'h0000, 16'h0018, 16'h0001, 16'h0000, 16'h0000, 16'h0018};
    rows[2] = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0018, 16'h0000,
                16'hFFFE, 16'h0000, 16'h0000, 16'h0018, 16'hFFFE, 16'h0000, 16'h0000, 16'h0018};
    rows[3] = '{16'h7FF0, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 16'h0020, 16'h0000,
                16'h8010, 16'h0000, 16'h0000, 16'h0020, 16'h8010, 16'h0000, 16'h0000, 16'h0020};
    rows[4] = '{16'h0100, 16'hFF00, 16'h0005, 16'h0008, 16'hFFF8, 16'h0030, 16'hFFF0, 16'h0010,
                16'h00F8, 16'hFF08, 16'hFFD5, 16'hFFF0, 16'h0130, 16'hFED0, 16'h0125, 16'h0060};
    rows[5] = '{16'h0001, 16'h0002, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'h7FF0, 16'h0010,
                16'h0001, 16'h0002, 16'h0003, 16'h7FF0, 16'h0001, 16'h0002, 16'h0003, 16'h8060};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid || !in_ready || pt_x != 0 || pt_y != 0 || pt_z != 0 || pt_t != 0 || pt_idx != 0 || pt_last) begin
      failures++;
      $display("FAIL reset: got v=%0b rdy=%0b (%h,%h,%h) t=%h idx=%0d last=%0b want v=0 rdy=1 all zero",
               out_valid, in_ready, pt_x, pt_y, pt_z, pt_t, pt_idx, pt_last);
    end

    for (int i = 0; i < 6; i++) send_row(rows[i]);

    // Backpressure at k=3 with in_valid held high across the whole ray
    @(posedge clk); #1;
    drive(rows[0]);
    in_valid = 1'b1;
    wait_ready("bp_accept");
    repeat (4) @(posedge clk);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (!out_valid || pt_idx != 3'd3 || in_ready) begin
        failures++;
        $display("FAIL bp_stall: got v=%0b idx=%0d rdy=%0b want v=1 idx=3 rdy=0", out_valid, pt_idx, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_ready("bp_second");
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL bp_pending: got %0d samples outstanding, want 0 before second accept", sbq.size());
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_ready("bp_drain");
    repeat (N + 2) @(negedge clk);
    checks++;
    if (sbq.size() != 0 || !in_ready) begin
      failures++;
      $display("FAIL bp_done: got outstanding=%0d rdy=%0b want 0 and 1", sbq.size(), in_ready);
    end

    // Reset while sample 5 is presented
    @(posedge clk); #1;
    drive(rows[4]);
    in_valid = 1'b1;
    wait_ready("rst_accept");
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (pt_idx != 3'd5 || !out_valid) begin
      failures++;
      $display("FAIL rst_pos: got idx=%0d v=%0b want idx=5 v=1", pt_idx, out_valid);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid || !in_ready || pt_x != 0 || pt_y != 0 || pt_z != 0 || pt_t != 0 || pt_idx != 0 || pt_last) begin
      failures++;
      $display("FAIL midray_reset: got v=%0b rdy=%0b (%h,%h,%h) t=%h idx=%0d last=%0b want v=0 rdy=1 all zero",
               out_valid, in_ready, pt_x, pt_y, pt_z, pt_t, pt_idx, pt_last);
    end
    send_row(rows[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
